// File: rtl/pcpi_serial_bridge.sv
// pcpi_serial_bridge: segment-serial front end for a PCPI co-processor.
// The instruction arrives LSB segment first over a four-phase handshake.
// It is issued with a held pcpi_valid. A written-back pcpi_rd is returned
// serially, LSB segment first, over a second four-phase channel.
// Optional feature: define PCPI_TIMEOUT_EN to bound the PCPI wait to TIMEOUT
// counted cycles. Cycles with pcpi_wait=1 are not counted.
module pcpi_serial_bridge #(
  parameter int SEG_W   = 4,
  parameter int INSN_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [SEG_W-1:0]  in_data,
  output logic              in_ack,
  output logic              out_valid,
  output logic [SEG_W-1:0]  out_data,
  input  logic              out_ack,
  output logic              pcpi_valid,
  output logic [INSN_W-1:0] pcpi_insn,
  input  logic              pcpi_ready,
  input  logic              pcpi_wr,
  input  logic [DATA_W-1:0] pcpi_rd,
  input  logic              pcpi_wait,
  output logic              busy,
  output logic              timeout
);
  localparam int NSEG_IN  = INSN_W / SEG_W;
  localparam int NSEG_OUT = DATA_W / SEG_W;
  localparam int SCW      = (NSEG_IN > 1) ? $clog2(NSEG_IN) : 1;
  localparam int OCW      = (NSEG_OUT > 1) ? $clog2(NSEG_OUT) : 1;

  // LDONE: last segment latched, waiting for in_ack to finish falling
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_LDONE, S_ISSUE, S_WAIT, S_SEND
  } state_t;

  state_t            state_q, state_d;
  logic [SCW-1:0]    seg_cnt_q, seg_cnt_d;
  logic [OCW-1:0]    out_cnt_q, out_cnt_d;
  logic [INSN_W-1:0] insn_q, insn_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              in_ack_q, in_ack_d;
  logic              out_valid_q, out_valid_d;
  logic              latch;

`ifdef PCPI_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT + 1);
  logic [TCW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic           timeout_q, timeout_d;
`else
  logic [31:0] unused_cfg;
  assign unused_cfg = {pcpi_wait, 31'(TIMEOUT)};
`endif

  // State and datapath registers; reset abandons any transfer in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      seg_cnt_q   <= '0;
      out_cnt_q   <= '0;
      insn_q      <= '0;
      rd_q        <= '0;
      in_ack_q    <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef PCPI_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      seg_cnt_q   <= seg_cnt_d;
      out_cnt_q   <= out_cnt_d;
      insn_q      <= insn_d;
      rd_q        <= rd_d;
      in_ack_q    <= in_ack_d;
      out_valid_q <= out_valid_d;
`ifdef PCPI_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  // Next state: input handshake, PCPI issue/wait, and serial result return
  always_comb begin
    state_d     = state_q;
    seg_cnt_d   = seg_cnt_q;
    out_cnt_d   = out_cnt_q;
    insn_d      = insn_q;
    rd_d        = rd_q;
    in_ack_d    = in_ack_q;
    out_valid_d = out_valid_q;
`ifdef PCPI_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    timeout_d   = timeout_q;
`endif
    // Only a fresh request (ack low) latches, so a held in_valid latches once
    latch = in_valid && !in_ack_q && (state_q == S_IDLE || state_q == S_LOAD);
    if (latch) begin
      insn_d[SEG_W*int'(seg_cnt_q) +: SEG_W] = in_data;
      in_ack_d = 1'b1;
    end else if (in_ack_q && !in_valid) begin
      in_ack_d = 1'b0;
    end

    case (state_q)
      S_IDLE: if (latch) begin
`ifdef PCPI_TIMEOUT_EN
        timeout_d = 1'b0;
`endif
        if (NSEG_IN == 1) begin
          state_d = S_LDONE;
        end else begin
          state_d   = S_LOAD;
          seg_cnt_d = SCW'(1);
        end
      end
      S_LOAD: if (latch) begin
        if (seg_cnt_q == SCW'(NSEG_IN - 1)) begin
          state_d   = S_LDONE;
          seg_cnt_d = '0;
        end else begin
          seg_cnt_d = seg_cnt_q + SCW'(1);
        end
      end
      S_LDONE: if (!in_ack_q) begin
        state_d = S_ISSUE;
`ifdef PCPI_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      // ISSUE already honours pcpi_ready: one-cycle minimum issue latency
      S_ISSUE, S_WAIT: begin
        if (pcpi_ready) begin
          if (pcpi_wr) begin
            rd_d        = pcpi_rd;
            out_valid_d = 1'b1;
            state_d     = S_SEND;
          end else begin
            state_d = S_IDLE;
          end
        end else if (state_q == S_ISSUE) begin
          state_d = S_WAIT;
        end
`ifdef PCPI_TIMEOUT_EN
        else if (!pcpi_wait) begin
          if (tmo_cnt_q == TCW'(TIMEOUT - 1)) begin
            tmo_cnt_d = '0;
            timeout_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TCW'(1);
          end
        end
`endif
      end
      // A segment completes when out_ack is seen low after out_valid dropped
      S_SEND: begin
        if (out_valid_q) begin
          if (out_ack) out_valid_d = 1'b0;
        end else if (!out_ack) begin
          rd_d = rd_q >> SEG_W;
          if (out_cnt_q == OCW'(NSEG_OUT - 1)) begin
            out_cnt_d = '0;
            state_d   = S_IDLE;
          end else begin
            out_cnt_d   = out_cnt_q + OCW'(1);
            out_valid_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state
  always_comb begin
    pcpi_valid = (state_q == S_ISSUE) || (state_q == S_WAIT);
    pcpi_insn  = insn_q;
    in_ack     = in_ack_q;
    out_valid  = out_valid_q;
    out_data   = rd_q[SEG_W-1:0];
    busy       = (state_q != S_IDLE);
`ifdef PCPI_TIMEOUT_EN
    timeout    = timeout_q;
`else
    timeout    = 1'b0;
`endif
  end
endmodule

// File: tb/tb_pcpi_serial_bridge.sv
// Directed bench for pcpi_serial_bridge. A reference model holds the expected
// instruction word and a queue of expected result segments. A compare process
// checks the DUT against the model on every falling edge.
module tb_pcpi_serial_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ack, out_valid, out_ack;
  logic [3:0]  in_data, out_data;
  logic        pcpi_valid, pcpi_ready, pcpi_wr, pcpi_wait, busy, timeout;
  logic [31:0] pcpi_insn, pcpi_rd;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_insn = '0;
  logic [3:0]  exp_out[$];
  logic [3:0]  got_out[$];
  logic        ov_prev = 1'b0;

  localparam int IA = 0, PV = 1, OV = 2;

  always #5 clk = ~clk;

  pcpi_serial_bridge #(.SEG_W(4), .INSN_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ack(in_ack),
    .out_valid(out_valid), .out_data(out_data), .out_ack(out_ack),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_ready(pcpi_ready),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait),
    .busy(busy), .timeout(timeout)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      IA:      return in_ack;
      PV:      return pcpi_valid;
      default: return out_valid;
    endcase
  endfunction

  // Compare process: model versus DUT on every falling edge
  always @(negedge clk) begin
    if (!rst) begin
      if (pcpi_valid) chk("pcpi_insn vs model", pcpi_insn, exp_insn);
      if (pcpi_valid || out_valid) chk("busy while active", busy, 1);
      if (out_valid && !ov_prev) begin
        if (exp_out.size() == 0) chk("out_valid with no result pending", out_valid, 0);
        else begin
          got_out.push_back(out_data);
          chk("out_data vs model", out_data, exp_out.pop_front());
        end
      end
`ifndef PCPI_TIMEOUT_EN
      chk("timeout tied low", timeout, 0);
`endif
    end
    ov_prev = out_valid;
  end

  task automatic wait_sig(input int sel, input logic val, input string nm, output int cyc);
    cyc = 0;
    repeat (50) begin
      @(negedge clk);
      cyc++;
      if (sig(sel) === val) return;
    end
    chk({nm, " wait expired"}, sig(sel), val);
  endtask

  task automatic send_seg(input logic [3:0] d);
    int c;
    in_valid = 1'b1; in_data = d;
    wait_sig(IA, 1'b1, "in_ack rise", c);
    in_valid = 1'b0;
    wait_sig(IA, 1'b0, "in_ack fall", c);
  endtask

  task automatic send_word(input logic [31:0] w);
    exp_insn = w;
    for (int k = 0; k < 8; k++) send_seg(w[4*k +: 4]);
  endtask

  // Waits for issue, answers after d further cycles, checks the valid drop
  task automatic respond(input int d, input logic wr, input logic [31:0] rd);
    int c;
    wait_sig(PV, 1'b1, "pcpi_valid rise", c);
    chk("issue latency after load", c, 1);
    repeat (d) begin
      @(negedge clk);
      chk("pcpi_valid held", pcpi_valid, 1);
    end
    pcpi_ready = 1'b1; pcpi_wr = wr; pcpi_rd = rd;
    if (wr) for (int k = 0; k < 8; k++) exp_out.push_back(rd[4*k +: 4]);
    @(negedge clk);
    pcpi_ready = 1'b0; pcpi_wr = 1'b0;
    chk("pcpi_valid drop", pcpi_valid, 0);
  endtask

  task automatic drain(output logic [31:0] word);
    int c;
    got_out.delete();
    for (int k = 0; k < 8; k++) begin
      wait_sig(OV, 1'b1, "out_valid rise", c);
      out_ack = 1'b1;
      wait_sig(OV, 1'b0, "out_valid fall", c);
      out_ack = 1'b0;
    end
    @(negedge clk);
    chk("busy low after send", busy, 0);
    word = '0;
    for (int k = 0; k < got_out.size() && k < 8; k++) word[4*k +: 4] = got_out[k];
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int n, c;
    rst = 1'b1; in_valid = 0; in_data = 0; out_ack = 0;
    pcpi_ready = 0; pcpi_wr = 0; pcpi_rd = 0; pcpi_wait = 0;
    repeat (3) @(negedge clk);
    chk("reset pcpi_valid", pcpi_valid, 0);
    chk("reset pcpi_insn", pcpi_insn, 0);
    chk("reset in_ack", in_ack, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset timeout", timeout, 0);
    rst = 1'b0;
    @(negedge clk);

    // Load 8,7,...,1 and write back DEADBEEF after three wait cycles
    send_word(32'h12345678);
    chk("pcpi_valid low at final ack fall", pcpi_valid, 0);
    respond(3, 1'b1, 32'hDEADBEEF);
    drain(w);
    chk("result word reassembled", w, 32'hDEADBEEF);
    chk("first result segment", got_out[0], 4'hF);
    chk("last result segment", got_out[7], 4'hD);
    chk("insn literal", pcpi_insn, 32'h12345678);

    // Held request on segment 0, then a result-less completion
    exp_insn = 32'h0BADF00D;
    in_valid = 1'b1; in_data = 4'hD;
    repeat (10) begin
      @(negedge clk);
      chk("in_ack held", in_ack, 1);
    end
    in_valid = 1'b0;
    wait_sig(IA, 1'b0, "held in_ack fall", c);
    for (int k = 1; k < 8; k++) send_seg(exp_insn[4*k +: 4]);
    respond(2, 1'b0, 32'hFFFFFFFF);
    repeat (3) begin
      @(negedge clk);
      chk("no write-back out_valid", out_valid, 0);
      chk("no write-back busy", busy, 0);
    end
    chk("held-request insn", pcpi_insn, 32'h0BADF00D);

    // Reset after four segments, then a clean word
    exp_insn = 32'h99991234;
    for (int k = 0; k < 4; k++) send_seg(exp_insn[4*k +: 4]);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid-load reset busy", busy, 0);
    chk("mid-load reset insn", pcpi_insn, 0);
    send_word(32'hA5A5A5A5);
    respond(1, 1'b0, 32'h0);
    chk("insn after reset", pcpi_insn, 32'hA5A5A5A5);

    // Reset while pcpi_valid is held
    send_word(32'h00C0FFEE);
    wait_sig(PV, 1'b1, "pcpi_valid rise", c);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("reset drops pcpi_valid", pcpi_valid, 0);
    chk("reset drops busy", busy, 0);

    // Ready in the ISSUE cycle with write-back
    send_word(32'hCAFEF00D);
    respond(0, 1'b1, 32'h0123ABCD);
    drain(w);
    chk("fast result word", w, 32'h0123ABCD);

`ifdef PCPI_TIMEOUT_EN
    // No ready: 16 counted cycles plus 5 stalled cycles in WAIT
    send_word(32'h00000013);
    wait_sig(PV, 1'b1, "pcpi_valid rise", c);
    n = 1;
    repeat (40) begin
      @(negedge clk);
      if (!pcpi_valid) break;
      n++;
      pcpi_wait = (n >= 2 && n <= 6);
    end
    pcpi_wait = 1'b0;
    chk("valid cycles before timeout", n, 22);
    chk("timeout set", timeout, 1);
    chk("busy after timeout", busy, 0);
    chk("no output on timeout", out_valid, 0);
    in_valid = 1'b1; in_data = 4'h3;
    wait_sig(IA, 1'b1, "in_ack rise", c);
    chk("timeout cleared on first latch", timeout, 0);
    in_valid = 1'b0;
    wait_sig(IA, 1'b0, "in_ack fall", c);
    for (int k = 1; k < 8; k++) send_seg(exp_insn[4*k +: 4]);
    respond(0, 1'b0, 32'h0);
`endif

    repeat (2) @(negedge clk);
    chk("model queue empty", exp_out.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pcpi_serial_bridge.md
Name: pcpi_serial_bridge

Overview:
- Parametrised successor to the nibble-serial PCPI front end.
- Receives an instruction word over a narrow pin-limited interface, one SEG_W-bit segment per handshake, LSB segment first.
- Issues the word to a PCPI co-processor with a held-valid handshake.
- If the co-processor writes back, returns pcpi_rd serially over a second handshake channel. Sits between the chip IO pins and the PCPI unit.

Parameters:
- SEG_W, 4, segment width in bits; must divide INSN_W and DATA_W.
- INSN_W, 32, instruction width; NSEG_IN = INSN_W/SEG_W.
- DATA_W, 32, result width; NSEG_OUT = DATA_W/SEG_W.
- TIMEOUT, 255, max PCPI wait cycles; used only with PCPI_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  host: in_data is valid (four-phase request)
- in_data  in  SEG_W  instruction segment
- in_ack  out  1  segment latched; held until in_valid falls
- out_valid  out  1  out_data valid (four-phase request)
- out_data  out  SEG_W  result segment
- out_ack  in  1  host has taken out_data
- pcpi_valid  out  1  instruction valid to co-processor
- pcpi_insn  out  INSN_W  latched instruction
- pcpi_ready  in  1  co-processor done
- pcpi_wr  in  1  result valid with pcpi_ready
- pcpi_rd  in  DATA_W  result
- pcpi_wait  in  1  co-processor requests extra time
- busy  out  1  high in any state except IDLE
- timeout  out  1  sticky; cleared at start of next instruction (0 when feature off)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs 0, pcpi_insn 0, state IDLE, counters 0.
- Reset mid-operation: abandons everything, including a held pcpi_valid.
- Input handshake, four-phase:
  - in_valid=1 with in_ack=0: latch in_data into slot seg_cnt (bits SEG_W*(k+1)-1:SEG_W*k) and set in_ack next cycle.
  - in_ack stays 1 until in_valid=0 is sampled, then drops next cycle.
  - A held in_valid never latches twice.
  - in_valid is ignored in every state except IDLE/LOAD.
- States:
  - IDLE: wait for in_valid. On the first latch clear timeout and go to LOAD with seg_cnt=1. If NSEG_IN=1, go straight to LOAD_DONE.
  - LOAD: accept segments; seg_cnt increments per latch. After the last segment (seg_cnt=NSEG_IN-1) is latched and in_ack has completed its fall, go to ISSUE.
  - ISSUE: drive pcpi_valid=1, pcpi_insn stable. Go to WAIT the same cycle.
  - WAIT: pcpi_valid held 1 until pcpi_ready=1 is sampled, then pcpi_valid=0 next cycle.
    - If pcpi_wr=1, capture pcpi_rd into the shift register and go to SEND.
    - Else go to IDLE.
    - pcpi_ready in the first ISSUE cycle is honoured: minimum issue latency is 1 cycle.
  - SEND:
    - out_data = rd[SEG_W-1:0], out_valid=1.
    - On out_ack=1: drop out_valid next cycle.
    - When out_ack=0 is sampled: shift rd right by SEG_W, increment out_cnt, raise out_valid again.
    - After NSEG_OUT segments complete, return to IDLE.
- busy follows the state register (registered).
- Segment counters wrap to 0 on return to IDLE.

Optional Feature:
- Macro PCPI_TIMEOUT_EN.
- Defined:
  - WAIT counts cycles in which pcpi_wait=0; cycles with pcpi_wait=1 neither count nor reset the counter.
  - When the count reaches TIMEOUT: pcpi_valid=0, timeout=1, state IDLE, no output transfer.
  - pcpi_ready on the same cycle as expiry wins (normal completion).
- Undefined: WAIT is unbounded; timeout tied 0; no counter logic.

Test Plan:
All scenarios use defaults (SEG_W=4, INSN_W=32, DATA_W=32).
- Load and write-back: send 8,7,6,5,4,3,2,1 with full four-phase handshake -> pcpi_insn=0x12345678, pcpi_valid rises after the 8th in_ack falls. Ready 3 cycles later with wr=1, rd=0xDEADBEEF -> out_data sequence F,E,E,B,D,A,E,D, then busy=0.
- Held request: hold in_valid high 10 cycles on segment 0 -> exactly one latch, seg_cnt=1, in_ack high until in_valid drops.
- No write-back: ready with wr=0 -> pcpi_valid drops next cycle, out_valid never rises, IDLE.
- Reset mid-load: rst after 4 segments, then a fresh 8-segment word 0xA5A5A5A5 -> pcpi_insn=0xA5A5A5A5 with no residue.
- Timeout (PCPI_TIMEOUT_EN, TIMEOUT=16): never assert ready, pcpi_wait high for 5 cycles -> pcpi_valid falls after 21 WAIT cycles, timeout=1. Timeout clears on the next first-segment latch.
- Ready in the first ISSUE cycle with wr=1 -> result captured and streamed correctly.
